// File: rtl/chord_wave_pkg.sv
// Shared types and constants for the chord waveform capture/display path.
// The write address is laid out as {channel, buffer, index}.
package chord_wave_pkg;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2
   } cap_state_e;

   localparam int unsigned NUM_CH       = 4;
   localparam int unsigned CH_BITS      = 2;
   localparam int unsigned SAMPLE_W     = 16;
   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned DEF_IDX_BITS = 8;

   typedef logic [CH_BITS-1:0] ch_t;

   localparam ch_t CH_ALL   = 2'd0;
   localparam ch_t CH_ONE   = 2'd1;
   localparam ch_t CH_TWO   = 2'd2;
   localparam ch_t CH_THREE = 2'd3;

   // Sample RAM address for the default capture length; the reader decodes with this.
   typedef struct packed {
      ch_t                     ch;
      logic                    buffer;
      logic [DEF_IDX_BITS-1:0] idx;
   } wr_addr_t;

   // Top byte of a signed sample, shifted to offset binary.
   function automatic logic [BYTE_W-1:0] to_offset_byte(input logic [BYTE_W-1:0] hi);
      return {~hi[BYTE_W-1], hi[BYTE_W-2:0]};
   endfunction

endpackage

// File: rtl/chord_wave_capture_if.sv
// Sample-in / RAM-write-out bundle of the capture engine.
// master drives samples and reads the write port; slave is the capture engine.
interface chord_wave_capture_if
   import chord_wave_pkg::*;
#(
   parameter int unsigned IDX_BITS = 8
) ();

   logic                    new_sample_ready;
   logic [SAMPLE_W-1:0]     sample_all;
   logic [SAMPLE_W-1:0]     sample_one;
   logic [SAMPLE_W-1:0]     sample_two;
   logic [SAMPLE_W-1:0]     sample_three;
   logic                    wave_display_idle;
   logic [IDX_BITS+2:0]     write_address;
   logic                    write_enable;
   logic [BYTE_W-1:0]       write_sample;
   logic                    read_index;
   logic                    overrun;

   modport master (
      output new_sample_ready, sample_all, sample_one, sample_two, sample_three,
             wave_display_idle,
      input  write_address, write_enable, write_sample, read_index, overrun
   );

   modport slave (
      input  new_sample_ready, sample_all, sample_one, sample_two, sample_three,
             wave_display_idle,
      output write_address, write_enable, write_sample, read_index, overrun
   );

endinterface

// File: rtl/capture_lane_mux.sv
// Latches the four voice samples and serializes them, one channel per cycle,
// as offset-binary bytes onto the single RAM write port.
module capture_lane_mux
   import chord_wave_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic [SAMPLE_W-1:0] sample_all_i,
   input  logic [SAMPLE_W-1:0] sample_one_i,
   input  logic [SAMPLE_W-1:0] sample_two_i,
   input  logic [SAMPLE_W-1:0] sample_three_i,
   output logic                busy_o,
   output ch_t                 ch_o,
   output logic [BYTE_W-1:0]   byte_o
);

   localparam int unsigned HI_LSB = SAMPLE_W - BYTE_W;

   logic [BYTE_W-1:0] lane_q [NUM_CH];
   logic              busy_q;
   ch_t               ch_q;
   logic [BYTE_W-1:0] byte_q;

   // Only the top byte of each sample reaches the display.
   logic unused_low_c;
   assign unused_low_c = ^{sample_all_i[HI_LSB-1:0], sample_one_i[HI_LSB-1:0],
                           sample_two_i[HI_LSB-1:0], sample_three_i[HI_LSB-1:0]};

   // Channel 0 goes out on the cycle after the load; the rest follow from the lanes.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         ch_q   <= CH_ALL;
         byte_q <= '0;
         for (int c = 0; c < NUM_CH; c++) lane_q[c] <= '0;
      end else if (load_i) begin
         lane_q[CH_ALL]   <= to_offset_byte(sample_all_i[SAMPLE_W-1:HI_LSB]);
         lane_q[CH_ONE]   <= to_offset_byte(sample_one_i[SAMPLE_W-1:HI_LSB]);
         lane_q[CH_TWO]   <= to_offset_byte(sample_two_i[SAMPLE_W-1:HI_LSB]);
         lane_q[CH_THREE] <= to_offset_byte(sample_three_i[SAMPLE_W-1:HI_LSB]);
         busy_q           <= 1'b1;
         ch_q             <= CH_ALL;
         byte_q           <= to_offset_byte(sample_all_i[SAMPLE_W-1:HI_LSB]);
      end else if (busy_q) begin
         if (ch_q == CH_THREE) begin
            busy_q <= 1'b0;
            ch_q   <= CH_ALL;
         end else begin
            ch_q   <= ch_t'(ch_q + 2'd1);
            byte_q <= lane_q[ch_t'(ch_q + 2'd1)];
         end
      end
   end

   assign busy_o = busy_q;
   assign ch_o   = ch_q;
   assign byte_o = byte_q;

endmodule

// File: rtl/chord_wave_capture.sv
// Chord waveform capture: trigger on a rising zero crossing of the summed voice,
// record 2^IDX_BITS samples of four channels into the buffer half the display is not reading.
module chord_wave_capture
   import chord_wave_pkg::*;
#(
   parameter int unsigned IDX_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   chord_wave_capture_if.slave   bus
);

   localparam int unsigned ADDR_W = IDX_BITS + 3;
   localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

   cap_state_e          state_q, state_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic                prev_neg_q, prev_neg_d;
   logic                read_index_q, read_index_d;
   logic                overrun_q, overrun_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;

   logic                accept_c;
   logic                load_c;
   logic                lane_last_c;
   logic                lane_busy;
   ch_t                 lane_ch;
   logic [BYTE_W-1:0]   lane_byte;

   capture_lane_mux u_lane_mux (
      .clk            (clk),
      .reset          (reset),
      .load_i         (load_c),
      .sample_all_i   (bus.sample_all),
      .sample_one_i   (bus.sample_one),
      .sample_two_i   (bus.sample_two),
      .sample_three_i (bus.sample_three),
      .busy_o         (lane_busy),
      .ch_o           (lane_ch),
      .byte_o         (lane_byte)
   );

   assign lane_last_c = lane_busy && (lane_ch == CH_THREE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARMED;
         idx_q        <= '0;
         prev_neg_q   <= 1'b0;
         read_index_q <= 1'b0;
         overrun_q    <= 1'b0;
         addr_q       <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         prev_neg_q   <= prev_neg_d;
         read_index_q <= read_index_d;
         overrun_q    <= overrun_d;
         addr_q       <= addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      prev_neg_d   = prev_neg_q;
      read_index_d = read_index_q;
      overrun_d    = overrun_q;
      addr_d       = addr_q;
      load_c       = 1'b0;

      // A strobe while the serializer is busy is dropped entirely.
      accept_c = bus.new_sample_ready && !lane_busy;
      if (bus.new_sample_ready && lane_busy) overrun_d = 1'b1;
      if (accept_c) prev_neg_d = bus.sample_all[SAMPLE_W-1];

      unique case (state_q)
         ARMED: begin
            if (accept_c && prev_neg_q && !bus.sample_all[SAMPLE_W-1]) begin
               load_c  = 1'b1;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (accept_c) load_c = 1'b1;
            if (lane_last_c) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_LAST) state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.wave_display_idle) begin
               state_d      = ARMED;
               read_index_d = ~read_index_q;
               idx_d        = '0;
            end
         end
         default: state_d = ARMED;
      endcase

      // Address tracks the channel the lane mux is about to present.
      if (load_c)
         addr_d = {CH_ALL, ~read_index_q, idx_q};
      else if (lane_busy && !lane_last_c)
         addr_d = {ch_t'(lane_ch + 2'd1), ~read_index_q, idx_q};
   end

   assign bus.write_enable  = lane_busy;
   assign bus.write_sample  = lane_byte;
   assign bus.write_address = addr_q;
   assign bus.read_index    = read_index_q;
   assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_chord_wave_capture.sv
// Scoreboard bench for chord_wave_capture: a behavioural model queues the expected
// RAM writes per strobe, and observed writes are popped against them.
module tb_chord_wave_capture;
   import chord_wave_pkg::*;

   localparam int unsigned IDX_BITS = 8;
   localparam int DEPTH = 1 << IDX_BITS;
   localparam int LOG_N = 4096;

   typedef struct packed {
      wr_addr_t    addr;
      logic [7:0]  data;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   chord_wave_capture_if #(.IDX_BITS(IDX_BITS)) bus ();

   chord_wave_capture #(.IDX_BITS(IDX_BITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   wr_t  exp_q[$];
   wr_t  obs_log [LOG_N];
   int   n_wr = 0;
   int   rd_ptr = 0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   cap_state_e m_state = ARMED;
   int         m_idx = 0;
   logic       m_prev = 1'b0;
   logic       m_rd = 1'b0;
   int         last_load = -100;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every RAM write seen outside reset.
   always @(negedge clk) begin
      if (!reset && bus.write_enable && n_wr < LOG_N) begin
         obs_log[n_wr] = '{addr: wr_addr_t'(bus.write_address), data: bus.write_sample};
         n_wr = n_wr + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [15:0] s);
      logic [15:0] shifted;
      shifted = s >> 8;
      return shifted[7:0] ^ 8'h80;
   endfunction

   task automatic drain();
      wr_t e;
      while (rd_ptr < n_wr) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_write", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_val("wr_addr", 32'(obs_log[rd_ptr].addr), 32'(e.addr));
            check_val("wr_data", 32'(obs_log[rd_ptr].data), 32'(e.data));
         end
         rd_ptr++;
      end
   endtask

   task automatic push_load(input logic [15:0] a, o, t2, t3);
      logic [15:0] s [4];
      s[0] = a; s[1] = o; s[2] = t2; s[3] = t3;
      for (int c = 0; c < 4; c++)
         exp_q.push_back('{addr: '{ch: ch_t'(c), buffer: ~m_rd, idx: 8'(m_idx)},
                          data: exp_byte(s[c])});
   endtask

   // Drive one strobe and advance the model; gap = cycles to the next strobe (>= 2).
   task automatic strobe(input logic [15:0] a, o, t2, t3, input int gap);
      int p;
      @(negedge clk);
      bus.sample_all       = a;
      bus.sample_one       = o;
      bus.sample_two       = t2;
      bus.sample_three     = t3;
      bus.new_sample_ready = 1'b1;
      p = cyc + 1;
      if (!(p - last_load >= 1 && p - last_load <= 4)) begin
         if ((m_state == ARMED && m_prev && !a[15]) || m_state == ACTIVE) begin
            m_state = ACTIVE;
            push_load(a, o, t2, t3);
            last_load = p;
            m_idx++;
            if (m_idx == DEPTH) begin
               m_idx = 0;
               m_state = WAIT;
            end
         end
         m_prev = a[15];
      end
      @(negedge clk);
      bus.new_sample_ready = 1'b0;
      repeat (gap - 2) @(negedge clk);
      drain();
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_we"},   32'(bus.write_enable), 32'd0);
      check_val({pfx, "_addr"}, 32'(bus.write_address), 32'd0);
      check_val({pfx, "_data"}, 32'(bus.write_sample), 32'd0);
      check_val({pfx, "_rdidx"}, 32'(bus.read_index), 32'd0);
      check_val({pfx, "_ovr"},  32'(bus.overrun), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.new_sample_ready  = 1'b0;
      bus.sample_all        = '0;
      bus.sample_one        = '0;
      bus.sample_two        = '0;
      bus.sample_three      = '0;
      bus.wave_display_idle = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst0");
      reset = 1'b0;

      // First strobe after reset cannot trigger.
      base = n_wr;
      strobe(16'h1000, 16'h1111, 16'h2222, 16'h3333, 8);
      check_val("first_no_trig", 32'(n_wr - base), 32'd0);

      // Trigger on negative -> positive crossing.
      base = n_wr;
      strobe(16'hF000, 16'h0, 16'h0, 16'h0, 8);
      strobe(16'h0100, 16'h8000, 16'h7FFF, 16'h0000, 8);
      check_val("trig_count", 32'(n_wr - base), 32'd4);
      check_val("trig_d0", 32'(obs_log[base].data), 32'h81);
      check_val("trig_d1", 32'(obs_log[base+1].data), 32'h00);
      check_val("trig_d2", 32'(obs_log[base+2].data), 32'hFF);
      check_val("trig_d3", 32'(obs_log[base+3].data), 32'h80);
      check_val("trig_a0", 32'(obs_log[base].addr), 32'h100);
      check_val("trig_a3", 32'(obs_log[base+3].addr), 32'h700);

      // Rest of the capture.
      for (int i = 1; i < DEPTH; i++)
         strobe(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8);
      check_val("cap_count", 32'(n_wr - base), 32'd1024);
      check_val("cap_last_addr", 32'(obs_log[n_wr-1].addr), 32'h7FF);
      repeat (10) @(negedge clk);
      check_val("wait_rdidx_hold", 32'(bus.read_index), 32'd0);

      // Strobes in WAIT write nothing, even a would-be trigger.
      base = n_wr;
      strobe(16'hF000, 16'h0, 16'h0, 16'h0, 8);
      strobe(16'h0100, 16'h0, 16'h0, 16'h0, 8);
      check_val("wait_no_write", 32'(n_wr - base), 32'd0);

      // Buffer swap on display idle.
      @(negedge clk);
      bus.wave_display_idle = 1'b1;
      @(negedge clk);
      bus.wave_display_idle = 1'b0;
      m_state = ARMED; m_rd = ~m_rd; m_idx = 0;
      check_val("swap_rdidx", 32'(bus.read_index), 32'd1);

      // Next capture into buffer 0, with an overrunning strobe.
      base = n_wr;
      strobe(16'h8000, 16'h0, 16'h0, 16'h0, 8);
      strobe(16'h0200, 16'h4000, 16'hC000, 16'h1234, 2);
      strobe(16'h8000, 16'h5555, 16'h6666, 16'h7777, 8);
      check_val("ovr_count", 32'(n_wr - base), 32'd4);
      check_val("ovr_set", 32'(bus.overrun), 32'd1);
      check_val("buf0_addr", 32'(obs_log[base].addr), 32'h000);

      while (m_idx != 100)
         strobe(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 6);
      check_val("ovr_sticky", 32'(bus.overrun), 32'd1);

      // Reset in the middle of serializing index 100.
      strobe(16'h2345, 16'h3456, 16'h4567, 16'h5678, 2);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_mid");
      reset = 1'b0;
      drain();
      exp_q.delete();
      m_state = ARMED; m_idx = 0; m_prev = 1'b0; m_rd = 1'b0; last_load = -100;

      // After reset: ARMED, prev_neg cleared, index 0, buffer 1.
      base = n_wr;
      strobe(16'h1000, 16'h0, 16'h0, 16'h0, 8);
      check_val("post_rst_no_trig", 32'(n_wr - base), 32'd0);
      strobe(16'hF000, 16'h0, 16'h0, 16'h0, 8);
      strobe(16'h0100, 16'hFFFF, 16'h0080, 16'h8100, 8);
      check_val("post_rst_count", 32'(n_wr - base), 32'd4);
      check_val("post_rst_addr", 32'(obs_log[base].addr), 32'h100);
      check_val("post_rst_ovr", 32'(bus.overrun), 32'd0);

      repeat (10) @(negedge clk);
      drain();
      check_val("exp_left", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
